// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush dominates push/pop.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch: one-outstanding imem requests, buffered responses, redirect flush.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    ifu_state_e   state, state_next;
    logic [63:0]  fetch_pc, fetch_pc_next;
    logic [63:0]  req_pc, req_pc_next;
    logic         drop, drop_next;
    logic         push, pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t head, push_entry;

    assign push_entry = '{pc: req_pc, inst: imem_resp_data};

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Redirect hides the head so a flushed entry can never be consumed.
    assign inst_valid     = !fifo_empty && !redirect_valid;
    assign pop            = inst_valid && inst_ready;
    assign inst           = head.inst;
    assign inst_pc        = head.pc;
    assign imem_req_addr  = fetch_pc;
    assign imem_req_valid = rst && (state == REQ) && !fifo_full && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
            drop     <= drop_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        drop_next     = drop;
        push          = 1'b0;
        case (state)
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_next = align_pc(redirect_pc);
                end else if (imem_req_valid && imem_req_ready) begin
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 64'd4;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_next = align_pc(redirect_pc);
                    if (imem_resp_valid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop) drop_next = 1'b0;
                    else      push      = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: fetch, backpressure, redirects, async reset.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    int checks = 0;
    int errors = 0;

    ifu dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout sim did not finish");
        $fatal(1, "timeout");
    end

    // Advance to 2 time units after the next rising edge; inputs change there.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_req(input string name, input logic exp_v, input logic [63:0] exp_a);
        // Inline checks of the request channel for one cycle.
        #1;
        checks++;
        if (imem_req_valid !== exp_v) begin
            errors++;
            $display("FAIL %s_req_valid got %0b exp %0b", name, imem_req_valid, exp_v);
        end
        if (exp_v) begin
            checks++;
            if (imem_req_addr !== exp_a) begin
                errors++;
                $display("FAIL %s_req_addr got %h exp %h", name, imem_req_addr, exp_a);
            end
        end
    endtask

    task automatic chk_inst(input string name, input logic exp_v,
                            input logic [31:0] exp_i, input logic [63:0] exp_pc);
        #1;
        checks++;
        if (inst_valid !== exp_v) begin
            errors++;
            $display("FAIL %s_inst_valid got %0b exp %0b", name, inst_valid, exp_v);
        end
        if (exp_v) begin
            checks++;
            if (inst !== exp_i || inst_pc !== exp_pc) begin
                errors++;
                $display("FAIL %s_inst got %h@%h exp %h@%h", name, inst, inst_pc, exp_i, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        tick();
        tick();
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%0b iv=%0b inst=%h pc=%h exp 0 0 0 0",
                     imem_req_valid, inst_valid, inst, inst_pc);
        end
        tick();
        rst = 1'b1;
        chk_req("reset_first", 1'b1, 64'h8000_0000);
    endtask

    // Cycle A is the first post-reset cycle; request is accepted at its edge.
    task automatic test_reset_fetch_and_backpressure();
        tick();                                   // WAIT
        chk_req("wait0", 1'b0, '0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        tick();                                   // REQ, 1 entry
        imem_resp_valid = 1'b0;
        chk_inst("fetch0", 1'b1, 32'h0000_0013, 64'h8000_0000);
        chk_req("fetch1", 1'b1, 64'h8000_0004);
        tick();                                   // WAIT
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        tick();                                   // REQ, full
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_req("bp_stall", 1'b0, '0);
            chk_inst("bp_hold", 1'b1, 32'h0000_0013, 64'h8000_0000);
            tick();
        end
        inst_ready = 1'b1;
        chk_inst("drain0", 1'b1, 32'h0000_0013, 64'h8000_0000);
        chk_req("drain0", 1'b0, '0);
        tick();                                   // pop; one entry left, request offered
        chk_inst("drain1", 1'b1, 32'h0010_0093, 64'h8000_0004);
        chk_req("resume", 1'b1, 64'h8000_0008);
        tick();                                   // pop + handshake -> WAIT, empty
        inst_ready = 1'b0;
        chk_inst("drained", 1'b0, '0, '0);
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        chk_req("rdw_gate", 1'b0, '0);
        tick();                                   // drop set, still WAIT
        redirect_valid = 1'b0;
        chk_req("rdw_wait", 1'b0, '0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hdead_beef;
        tick();                                   // dropped -> REQ
        imem_resp_valid = 1'b0;
        chk_inst("rdw_dropped", 1'b0, '0, '0);
        chk_req("rdw_target", 1'b1, 64'h8000_1000);
        tick();                                   // WAIT on 0x80001000
    endtask

    task automatic test_redirect_coincident();
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_2000;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        tick();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        chk_inst("rdc_dropped", 1'b0, '0, '0);
        chk_req("rdc_target", 1'b1, 64'h8000_2000);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_0113;
        tick();                                   // pushed: drop must be clear
        imem_resp_valid = 1'b0;
        chk_inst("rdc_next", 1'b1, 32'h0020_0113, 64'h8000_2000);
    endtask

    task automatic test_redirect_full();
        chk_req("rdf_req", 1'b1, 64'h8000_2004);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0030_0193;
        tick();                                   // full
        imem_resp_valid = 1'b0;
        chk_req("rdf_full", 1'b0, '0);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        chk_inst("rdf_gate", 1'b0, '0, '0);
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk_inst("rdf_flushed", 1'b0, '0, '0);
        chk_req("rdf_target", 1'b1, 64'h8000_3000);
    endtask

    task automatic test_async_reset();
        tick();                                   // WAIT on 0x80003000
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0040_0213;
        tick();
        imem_resp_valid = 1'b0;
        chk_inst("ar_pre", 1'b1, 32'h0040_0213, 64'h8000_3000);
        chk_req("ar_pre", 1'b1, 64'h8000_3004);
        tick();                                   // WAIT, one entry buffered
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got rv=%0b iv=%0b inst=%h pc=%h exp 0 0 0 0",
                     imem_req_valid, inst_valid, inst, inst_pc);
        end
        tick();
        tick();
        rst = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;                   // stale response must be ignored in REQ
        imem_resp_data  = 32'hbad0_bad0;
        chk_req("ar_restart", 1'b1, 64'h8000_0000);
        tick();
        imem_resp_valid = 1'b0;
        chk_inst("ar_stale", 1'b0, '0, '0);
        chk_req("ar_hold", 1'b1, 64'h8000_0000);
    endtask

    initial begin
        test_reset();
        test_reset_fetch_and_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_redirect_full();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle RV64 core. It generates sequential fetch addresses from a fetch PC and issues one-outstanding requests to instruction memory over a valid/ready handshake. Returned words are buffered in a small FIFO and presented to the core's decode/execute stage as `{inst_pc, inst}` with a valid/ready handshake. Redirects from the core (taken branch/jump) flush the buffer and discard any in-flight response.

## Interface
- `RESET_PC`: default 64'h0000000080000000. PC of the first fetch after reset.
- `FIFO_DEPTH`: default 2. Instruction buffer entries; must be ≥1.

- `clk`: in, 1. Single clock; all state on rising edge.
- `rst`: in, 1. Asynchronous, active-low reset.
- `redirect_valid`: in, 1. Core requests a fetch redirect this cycle.
- `redirect_pc`: in, 64. Redirect target; bits [1:0] are forced to 0.
- `inst_valid`: out, 1. Buffer head is valid for the core.
- `inst_ready`: in, 1. Core accepts the head this cycle.
- `inst`: out, 32. Instruction word at the buffer head.
- `inst_pc`: out, 64. PC of `inst`.
- `imem_req_valid`: out, 1. Fetch request valid.
- `imem_req_ready`: in, 1. Memory accepts the request.
- `imem_req_addr`: out, 64. Fetch address, 4-byte aligned.
- `imem_resp_valid`: in, 1. Response data valid; at least 1 cycle after acceptance, exactly one response per request.
- `imem_resp_data`: in, 32. Instruction word.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `req_pc`: PC of the outstanding request.
  - `drop`: discard the next response.
  - FSM state.
  - FIFO of `{pc, inst}`.
- FSM states:
  - **REQ** (reset state):
    - `imem_req_valid` = (count < FIFO_DEPTH) and not `redirect_valid`.
    - `imem_req_addr` = `fetch_pc`.
    - On handshake: `req_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc`+4 (64-bit wrap), → WAIT.
  - **WAIT**:
    - `imem_req_valid` = 0.
    - On `imem_resp_valid`: if `drop`, discard and clear `drop`; else push `{req_pc, imem_resp_data}`. Then → REQ.
- No push can overflow: issue requires count < FIFO_DEPTH with at most one request outstanding.
- Pop occurs when `inst_valid` && `inst_ready`. Push and pop in the same cycle leave count unchanged.
- Redirect (`redirect_valid`=1) has priority over everything:
  - FIFO count ← 0; `inst_valid` forced 0 combinationally in that cycle, so no pop occurs.
  - `fetch_pc` ← {`redirect_pc`[63:2], 2'b00}.
  - In REQ: no request is issued this cycle; stay in REQ.
  - In WAIT with `imem_resp_valid`=1: the response is discarded; → REQ with `drop`=0.
  - In WAIT without a response: `drop` ← 1; stay in WAIT.
  - A repeated redirect while `drop`=1 keeps `drop`=1 and updates `fetch_pc`.

## Timing
- Reset values (asynchronous):
  - state=REQ, `fetch_pc`=`RESET_PC`, `req_pc`=0, `drop`=0, FIFO empty.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - `imem_req_valid`=0 while `rst`=0.
- First request: the first cycle after `rst` deasserts, with `imem_req_addr`=0x80000000.
- Latency: response at edge N pushes into the FIFO; `inst_valid`=1 in the cycle after edge N.
- Peak throughput: one instruction per 2 cycles (REQ, WAIT). The response cycle moves to REQ, and the next request is offered in the following cycle.
- Reset asserted mid-transaction: all state clears. Memory must also be reset; any late response is ignored because the FSM is in REQ.
- `inst`/`inst_pc` hold the head entry stable while `inst_valid`=1 and `inst_ready`=0.

## Structure
- Package `ifu_pkg`:
  - `ifu_state_e` {REQ, WAIT}.
  - Typedef `fetch_entry_t` {logic [63:0] pc; logic [31:0] inst}.
  - Constant `IFU_RESET_PC`.
- Sub-module `ifu_fifo`:
  - Synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`.
  - Ports: push, pop, flush (flush dominates), head, count, empty, full.
  - Pointers wrap modulo `DEPTH`.
- `ifu` top contains the FSM, PC registers, drop flag and redirect gating.

## Test plan
- **Reset fetch:** release `rst`, memory ready=1, 1-cycle latency, returns 0x00000013 → first `imem_req_addr`=0x80000000. Returns 0x00000013 at `inst_pc`=0x80000000. Next request goes to 0x80000004.
- **Backpressure:** `inst_ready`=0, FIFO_DEPTH=2 → exactly 2 requests (0x80000000, 0x80000004), then `imem_req_valid` stays 0. Raising `inst_ready` drains both in order and fetching resumes at 0x80000008.
- **Redirect in WAIT:** request 0x80000008 outstanding, redirect to 0x80001002, response arrives 2 cycles later → response dropped. Next request to 0x80001000. No `inst_valid` for 0x80000008.
- **Redirect coincident with response:** redirect to 0x80002000 in the same cycle as `imem_resp_valid` → response discarded, `drop`=0, next request to 0x80002000.
- **Redirect with full FIFO:** FIFO full, `inst_ready`=1, redirect asserted → `inst_valid`=0 that cycle, count=0 after the edge, no pop recorded.
- **Async reset mid-WAIT:** assert `rst`=0 between edges → outputs immediately at reset values. After release, fetch restarts at 0x80000000.
